bcd_score_arbiter: RTL and testbench
====================================

BCD_SCORE_ARBITER -- requirements
Module: bcd_score_arbiter

Interface
REQ-001 The block SHALL have a single clock, and reset SHALL be asynchronous and active-low.
REQ-002 Port clk SHALL be an input, 1 bit wide: the system clock; all state updates on its rising edge.
REQ-003 Port reset_n SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-004 Port req_a SHALL be an input, 1 bit wide: player A increment request, a level held until gnt_a.
REQ-005 Port req_b SHALL be an input, 1 bit wide: player B increment request, a level held until gnt_b.
REQ-006 Port clr SHALL be an input, 1 bit wide: synchronous score clear.
REQ-007 Port gnt_a SHALL be an output, 1 bit wide: one-cycle grant to A.
REQ-008 Port gnt_b SHALL be an output, 1 bit wide: one-cycle grant to B.
REQ-009 Port score SHALL be an output, 16 bits wide: four BCD digits, [3:0] least significant digit.
REQ-010 Port busy SHALL be an output, 1 bit wide: high while state is not IDLE.
REQ-011 Port upd SHALL be an output, 1 bit wide: one-cycle pulse when an increment completes.
REQ-012 Port ovf SHALL be an output, 1 bit wide: overflow indication, as defined by REQ-024 and REQ-025.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and ADD, plus a 2-bit digit index idx and a 1-bit round-robin pointer rr.
REQ-014 In IDLE with exactly one request high: at the next edge, assert that requester's grant for one cycle, go to ADD, set idx=0.
REQ-015 In IDLE with both requests high: grant the side selected by rr (0=A, 1=B); after any grant, rr points to the other side.
REQ-016 Each ADD cycle SHALL process digit[idx]: if less than 9, increment it, then go to IDLE and pulse upd; if 9, write 0 and increment idx (carry).
REQ-017 A carry out of digit 3 SHALL end the operation with score 0000 or saturation (REQ-024/REQ-025), then IDLE, and pulse upd.
REQ-018 Latency SHALL be: gnt one cycle after req sampled in IDLE; ADD lasts 1 + (number of trailing 9 digits) cycles, range 1..4.
REQ-019 Intermediate score values during ADD SHALL be legal BCD; score is architecturally valid only when busy=0.
REQ-020 Requests arriving during ADD SHALL wait; no grant is issued outside the IDLE→ADD transition.
REQ-021 A requester still holding req the cycle after its grant SHALL be treated as a new request once IDLE is reached.
REQ-022 clr SHALL take priority over everything in every state: score=0000, ovf=0, idx=0, state=IDLE at the next edge, with no grant and no upd that cycle; rr is unchanged.
REQ-023 Any in-flight ADD aborted by clr SHALL be lost; the granted request is not replayed.

Configuration
REQ-024 With macro BCD_SCORE_SATURATE_EN defined: an increment at 9999 SHALL take one ADD cycle, leave score at 9999, and set ovf sticky until clr or reset.
REQ-025 Without BCD_SCORE_SATURATE_EN: 9999+1 SHALL wrap to 0000 after four ADD cycles, with ovf pulsed high for one cycle, coincident with upd.

Reset
REQ-026 When reset_n=0, the block SHALL immediately force: score=0000, state=IDLE, idx=0, rr=0 (A first), gnt_a=gnt_b=0, busy=0, upd=0, ovf=0.
REQ-027 Reset asserted mid-ADD SHALL abandon the operation; after release, the first grant SHALL occur no earlier than the first rising edge with reset_n=1.

Verification
REQ-028 Single request: score=0000, req_a held until grant -> gnt_a 1 cycle; after one ADD cycle, score=0001, upd pulse, busy high exactly 1 cycle.
REQ-029 Carry ripple: score=0199, req_b -> three ADD cycles, final score=0200, one upd, gnt_b only.
REQ-030 Simultaneous requests after reset: req_a=req_b=1 held -> gnt_a first, gnt_b on the following IDLE, score +2, rr alternates.
REQ-031 Overflow without macro: score=9999, req_a -> four ADD cycles, score=0000, ovf and upd high for the same single cycle. With macro: score stays 9999, ovf stays 1 until clr.
REQ-032 clr mid-operation: score=0999, req_a, clr asserted during the second ADD cycle -> next edge gives score=0000, IDLE, no upd.
REQ-033 Async reset mid-ADD: reset_n low between edges during ADD -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bcd_score_arbiter.sv
// bcd_score_arbiter: round-robin two-player arbiter driving a 4-digit BCD score.
// Define BCD_SCORE_SATURATE_EN to saturate at 9999 with a sticky ovf flag.
module bcd_score_arbiter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_a,
   input  logic        req_b,
   input  logic        clr,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [15:0] score,
   output logic        busy,
   output logic        upd,
   output logic        ovf
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ADD  = 1'b1;

`ifdef BCD_SCORE_SATURATE_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   logic [0:0]  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        rr_q, rr_d;
   logic [15:0] score_q, score_d;
   logic        gnt_a_q, gnt_a_d;
   logic        gnt_b_q, gnt_b_d;
   logic        upd_q, upd_d;
   logic        ovf_q, ovf_d;

   logic [3:0]  digit;
   logic        grant_a;
   logic        grant_b;
   logic        sat_hit;

   // rr selects the winner only when both sides ask at once
   always_comb begin
      grant_a = req_a & (~req_b | ~rr_q);
      grant_b = req_b & (~req_a | rr_q);
      digit   = score_q[{idx_q, 2'b00} +: 4];
      sat_hit = SAT_EN & (score_q == 16'h9999);
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rr_d    = rr_q;
      score_d = score_q;
      gnt_a_d = 1'b0;
      gnt_b_d = 1'b0;
      upd_d   = 1'b0;
      ovf_d   = SAT_EN ? ovf_q : 1'b0;
      if (clr) begin
         state_d = S_IDLE;
         idx_d   = 2'd0;
         score_d = 16'h0000;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               unique case (1'b1)
                  grant_a: begin
                     gnt_a_d = 1'b1;
                     rr_d    = 1'b1;
                     state_d = S_ADD;
                     idx_d   = 2'd0;
                  end
                  grant_b: begin
                     gnt_b_d = 1'b1;
                     rr_d    = 1'b0;
                     state_d = S_ADD;
                     idx_d   = 2'd0;
                  end
                  default: ;
               endcase
            end
            S_ADD: begin
               if (sat_hit) begin
                  upd_d   = 1'b1;
                  ovf_d   = 1'b1;
                  state_d = S_IDLE;
                  idx_d   = 2'd0;
               end else if (digit != 4'd9) begin
                  score_d[{idx_q, 2'b00} +: 4] = digit + 4'd1;
                  upd_d   = 1'b1;
                  state_d = S_IDLE;
                  idx_d   = 2'd0;
               end else begin
                  // digit rolls to zero and the carry moves up one place
                  score_d[{idx_q, 2'b00} +: 4] = 4'd0;
                  if (idx_q == 2'd3) begin
                     upd_d   = 1'b1;
                     ovf_d   = 1'b1;
                     state_d = S_IDLE;
                     idx_d   = 2'd0;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         rr_q    <= 1'b0;
         score_q <= 16'h0000;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         upd_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
         score_q <= score_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         upd_q   <= upd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign gnt_a = gnt_a_q;
   assign gnt_b = gnt_b_q;
   assign score = score_q;
   assign busy  = (state_q == S_ADD);
   assign upd   = upd_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_score_arbiter.sv
// tb_bcd_score_arbiter: randomized bench with an integer-score reference model.
// Honours BCD_SCORE_SATURATE_EN for the overflow expectations.
module tb_bcd_score_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_a;
   logic        req_b;
   logic        clr;
   logic        gnt_a;
   logic        gnt_b;
   logic        busy;
   logic        upd;
   logic        ovf;
   logic [15:0] score;

   int n_checks = 0;
   int n_fail   = 0;

   int m_score;
   bit m_rr;

   int          ob_n, ob_upd, ob_lat, ob_stray, ob_both;
   bit          ob_tmo;
   bit          ob_side [2];
   int          ob_bc    [2];
   logic [15:0] ob_score [2];
   logic        ob_ovf   [2];

`ifdef BCD_SCORE_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   always #5 clk = ~clk;

   bcd_score_arbiter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req_a   (req_a),
      .req_b   (req_b),
      .clr     (clr),
      .gnt_a   (gnt_a),
      .gnt_b   (gnt_b),
      .score   (score),
      .busy    (busy),
      .upd     (upd),
      .ovf     (ovf)
   );

   function automatic logic [15:0] bcd(input int s);
      return {4'(s / 1000 % 10), 4'(s / 100 % 10),
              4'(s / 10 % 10), 4'(s % 10)};
   endfunction

   function automatic int inc(input int s);
      if (s == 9999) return SAT ? 9999 : 0;
      return s + 1;
   endfunction

   // one cycle for the digit that stops the carry, one per trailing 9
   function automatic int add_cycles(input int s);
      int n;
      int t;
      n = 0;
      t = s;
      if (SAT && s == 9999) return 1;
      while (t % 10 == 9 && n < 4) begin
         n++;
         t = t / 10;
      end
      return (n + 1 > 4) ? 4 : n + 1;
   endfunction

   task automatic serve(input bit ra, input bit rb);
      int bc;
      bit done;
      bc = 0;
      done = 1'b0;
      ob_n = 0; ob_upd = 0; ob_lat = 0;
      ob_stray = 0; ob_both = 0; ob_tmo = 1'b0;
      req_a = ra;
      req_b = rb;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (gnt_a && gnt_b) ob_both++;
         if (gnt_a || gnt_b) begin
            if (ob_n == 0) ob_lat = c + 1;
            if (ob_n < 2) ob_side[ob_n] = gnt_b;
            ob_n++;
            bc = 0;
            if (gnt_a) req_a = 1'b0;
            if (gnt_b) req_b = 1'b0;
         end
         if (busy) bc++;
         if (upd) begin
            if (ob_upd < 2) begin
               ob_bc[ob_upd]    = bc;
               ob_score[ob_upd] = score;
               ob_ovf[ob_upd]   = ovf;
            end
            ob_upd++;
         end else if (ovf) begin
            ob_stray++;
         end
         done = !req_a && !req_b && !busy;
      end
      if (!done) ob_tmo = 1'b1;
      req_a = 1'b0;
      req_b = 1'b0;
      @(negedge clk);
      if (upd) ob_upd++;
      if (ovf) ob_stray++;
   endtask

   // holds one request for n consecutive grants
   task automatic pump(input bit side, input int n, output int got);
      got = 0;
      if (n <= 0) return;
      if (side) req_b = 1'b1;
      else req_a = 1'b1;
      for (int c = 0; c < n * 6 + 10 && got < n; c++) begin
         @(negedge clk);
         if (side ? gnt_b : gnt_a) begin
            got++;
            if (got == n) begin
               req_a = 1'b0;
               req_b = 1'b0;
            end
         end
      end
      req_a = 1'b0;
      req_b = 1'b0;
      for (int c = 0; c < 10 && busy; c++) @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < n; i++) m_score = inc(m_score);
      m_rr = !side;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      m_score = 0;
      m_rr = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      req_a = 1'b0;
      req_b = 1'b0;
      clr = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      n_checks++;
      if ({gnt_a, gnt_b, busy, upd, ovf, score} !== 21'h0) begin
         n_fail++;
         $display("FAIL reset_async got=%h exp=0",
                  {gnt_a, gnt_b, busy, upd, ovf, score});
      end
      @(negedge clk);
      n_checks++;
      if ({gnt_a, gnt_b, busy, upd, ovf, score} !== 21'h0) begin
         n_fail++;
         $display("FAIL reset_held got=%h exp=0",
                  {gnt_a, gnt_b, busy, upd, ovf, score});
      end
      reset_n = 1'b1;
      m_score = 0;
      m_rr = 1'b0;
   endtask

   task automatic test_single();
      int ek;
      logic [15:0] es;
      ek = add_cycles(m_score);
      m_score = inc(m_score);
      es = bcd(m_score);
      serve(1'b1, 1'b0);
      m_rr = 1'b1;
      n_checks++;
      if (ob_tmo !== 1'b0 || ob_n !== 1) begin
         n_fail++;
         $display("FAIL single_grants got=%0d tmo=%0d exp=1", ob_n, ob_tmo);
      end
      n_checks++;
      if (ob_side[0] !== 1'b0 || ob_both !== 0) begin
         n_fail++;
         $display("FAIL single_side got=%0d exp=0", ob_side[0]);
      end
      n_checks++;
      if (ob_lat !== 1) begin
         n_fail++;
         $display("FAIL single_latency got=%0d exp=1", ob_lat);
      end
      n_checks++;
      if (ob_bc[0] !== ek) begin
         n_fail++;
         $display("FAIL single_busy got=%0d exp=%0d", ob_bc[0], ek);
      end
      n_checks++;
      if (ob_score[0] !== es) begin
         n_fail++;
         $display("FAIL single_score got=%h exp=%h", ob_score[0], es);
      end
      n_checks++;
      if (ob_upd !== 1) begin
         n_fail++;
         $display("FAIL single_upd got=%0d exp=1", ob_upd);
      end
   endtask

   task automatic test_simultaneous();
      serve(1'b1, 1'b1);
      m_score = m_score + 2;
      m_rr = 1'b0;
      n_checks++;
      if (ob_n !== 2 || ob_side[0] !== 1'b0 || ob_side[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_order got=%0d,%0d n=%0d exp=0,1 n=2",
                  ob_side[0], ob_side[1], ob_n);
      end
      n_checks++;
      if (ob_score[1] !== bcd(m_score) || ob_upd !== 2) begin
         n_fail++;
         $display("FAIL simul_score got=%h upd=%0d exp=%h upd=2",
                  ob_score[1], ob_upd, bcd(m_score));
      end
   endtask

   task automatic test_back_to_back();
      int got;
      pump(1'b1, 3, got);
      n_checks++;
      if (got !== 3) begin
         n_fail++;
         $display("FAIL b2b_grants got=%0d exp=3", got);
      end
      n_checks++;
      if (score !== bcd(m_score) || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_score got=%h exp=%h", score, bcd(m_score));
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 24; it++) begin
         int pat;
         int ng;
         bit ra, rb, w;
         int ek [2];
         logic [15:0] es [2];
         bit eo [2];
         pat = int'($urandom_range(3, 1));
         ra = pat[0];
         rb = pat[1];
         ng = (ra && rb) ? 2 : 1;
         w = (ra && rb) ? m_rr : rb;
         for (int i = 0; i < ng; i++) begin
            ek[i] = add_cycles(m_score);
            eo[i] = (m_score == 9999);
            m_score = inc(m_score);
            es[i] = bcd(m_score);
         end
         m_rr = (ng == 2) ? w : !w;
         serve(ra, rb);
         n_checks++;
         if (ob_tmo !== 1'b0 || ob_n !== ng || ob_upd !== ng) begin
            n_fail++;
            $display("FAIL rand%0d_count gnt=%0d upd=%0d tmo=%0d exp=%0d",
                     it, ob_n, ob_upd, ob_tmo, ng);
         end
         n_checks++;
         if (ob_side[0] !== w || ob_lat !== 1 || ob_both !== 0) begin
            n_fail++;
            $display("FAIL rand%0d_first got=%0d lat=%0d exp=%0d lat=1",
                     it, ob_side[0], ob_lat, w);
         end
         if (ng == 2) begin
            n_checks++;
            if (ob_side[1] !== !w) begin
               n_fail++;
               $display("FAIL rand%0d_second got=%0d exp=%0d",
                        it, ob_side[1], !w);
            end
         end
         for (int i = 0; i < ng && i < ob_upd; i++) begin
            n_checks++;
            if (ob_bc[i] !== ek[i] || ob_score[i] !== es[i]
                || ob_ovf[i] !== eo[i]) begin
               n_fail++;
               $display("FAIL rand%0d_op%0d got=%h/%0d/%0d exp=%h/%0d/%0d",
                        it, i, ob_score[i], ob_bc[i], ob_ovf[i],
                        es[i], ek[i], eo[i]);
            end
         end
         n_checks++;
         if (ob_stray !== 0) begin
            n_fail++;
            $display("FAIL rand%0d_ovf got=%0d exp=0", it, ob_stray);
         end
         repeat ($urandom_range(2, 0)) @(negedge clk);
      end
   endtask

   task automatic test_carry();
      int got;
      int n;
      n = 199 - m_score;
      pump(1'b0, n, got);
      n_checks++;
      if (got !== n || score !== bcd(199)) begin
         n_fail++;
         $display("FAIL carry_preload got=%h/%0d exp=0199/%0d", score, got, n);
      end
      serve(1'b0, 1'b1);
      m_score = inc(m_score);
      m_rr = 1'b0;
      n_checks++;
      if (ob_n !== 1 || ob_side[0] !== 1'b1 || ob_both !== 0) begin
         n_fail++;
         $display("FAIL carry_grant got=%0d n=%0d exp=1 n=1", ob_side[0], ob_n);
      end
      n_checks++;
      if (ob_bc[0] !== 3) begin
         n_fail++;
         $display("FAIL carry_cycles got=%0d exp=3", ob_bc[0]);
      end
      n_checks++;
      if (ob_score[0] !== bcd(m_score) || ob_upd !== 1) begin
         n_fail++;
         $display("FAIL carry_score got=%h upd=%0d exp=%h upd=1",
                  ob_score[0], ob_upd, bcd(m_score));
      end
   endtask

   task automatic test_clr_mid();
      int got;
      bit seen;
      pump(1'b0, 999 - m_score, got);
      n_checks++;
      if (score !== bcd(999)) begin
         n_fail++;
         $display("FAIL clr_preload got=%h exp=0999", score);
      end
      seen = 1'b0;
      req_a = 1'b1;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         seen = gnt_a;
      end
      req_a = 1'b0;
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL clr_grant got=0 exp=1");
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || score !== 16'h0990) begin
         n_fail++;
         $display("FAIL clr_second_add got=%h busy=%0d exp=0990 busy=1",
                  score, busy);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_checks++;
      if ({gnt_a, gnt_b, busy, upd, ovf, score} !== 21'h0) begin
         n_fail++;
         $display("FAIL clr_abort got=%h exp=0",
                  {gnt_a, gnt_b, busy, upd, ovf, score});
      end
      @(negedge clk);
      n_checks++;
      if ({gnt_a, gnt_b, busy, upd, score} !== 20'h0) begin
         n_fail++;
         $display("FAIL clr_no_replay got=%h exp=0",
                  {gnt_a, gnt_b, busy, upd, score});
      end
      m_score = 0;
      m_rr = 1'b1;
   endtask

   task automatic test_clr_idle();
      bit w;
      serve(1'b0, 1'b1);
      m_score = inc(m_score);
      m_rr = 1'b0;
      req_a = 1'b1;
      req_b = 1'b1;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_checks++;
      if ({gnt_a, gnt_b, busy, upd, score} !== 20'h0) begin
         n_fail++;
         $display("FAIL clr_idle got=%h exp=0", {gnt_a, gnt_b, busy, upd, score});
      end
      m_score = 0;
      w = m_rr;
      serve(1'b1, 1'b1);
      m_score = m_score + 2;
      n_checks++;
      if (ob_n !== 2 || ob_side[0] !== w || ob_score[1] !== bcd(m_score)) begin
         n_fail++;
         $display("FAIL clr_rr got=%0d/%h exp=%0d/%h",
                  ob_side[0], ob_score[1], w, bcd(m_score));
      end
   endtask

   task automatic test_overflow();
      int got;
      pump(1'b0, 9999 - m_score, got);
      n_checks++;
      if (score !== 16'h9999 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_preload got=%h/%0d exp=9999/0", score, ovf);
      end
      serve(1'b1, 1'b0);
      m_rr = 1'b1;
      n_checks++;
      if (ob_bc[0] !== add_cycles(9999) || ob_upd !== 1) begin
         n_fail++;
         $display("FAIL ovf_cycles got=%0d upd=%0d exp=%0d upd=1",
                  ob_bc[0], ob_upd, add_cycles(9999));
      end
      n_checks++;
      if (ob_score[0] !== bcd(inc(9999)) || ob_ovf[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_result got=%h/%0d exp=%h/1",
                  ob_score[0], ob_ovf[0], bcd(inc(9999)));
      end
`ifdef BCD_SCORE_SATURATE_EN
      serve(1'b0, 1'b1);
      m_rr = 1'b0;
      n_checks++;
      if (ob_score[0] !== 16'h9999 || ovf !== 1'b1 || ob_bc[0] !== 1) begin
         n_fail++;
         $display("FAIL ovf_sticky got=%h/%0d exp=9999/1", ob_score[0], ovf);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_checks++;
      if (ovf !== 1'b0 || score !== 16'h0000) begin
         n_fail++;
         $display("FAIL ovf_clr got=%h/%0d exp=0000/0", score, ovf);
      end
`else
      n_checks++;
      if (ob_stray !== 0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_pulse got=%0d/%0d exp=0/0", ob_stray, ovf);
      end
`endif
      m_score = 0;
   endtask

   task automatic test_async_reset();
      bit seen;
      seen = 1'b0;
      req_a = 1'b1;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         seen = gnt_a;
      end
      n_checks++;
      if (!seen || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_enter got=%0d/%0d exp=1/1", seen, busy);
      end
      #2 reset_n = 1'b0;
      req_b = 1'b1;
      #1;
      n_checks++;
      if ({gnt_a, gnt_b, busy, upd, ovf, score} !== 21'h0) begin
         n_fail++;
         $display("FAIL arst_immediate got=%h exp=0",
                  {gnt_a, gnt_b, busy, upd, ovf, score});
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({gnt_a, gnt_b, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL arst_hold got=%b exp=000", {gnt_a, gnt_b, busy});
      end
      @(negedge clk);
      reset_n = 1'b1;
      m_score = 0;
      m_rr = 1'b0;
      serve(1'b1, 1'b1);
      m_score = 2;
      n_checks++;
      if (ob_lat !== 1 || ob_side[0] !== 1'b0 || ob_score[1] !== bcd(m_score)) begin
         n_fail++;
         $display("FAIL arst_restart got=%0d/%0d/%h exp=1/0/%h",
                  ob_lat, ob_side[0], ob_score[1], bcd(m_score));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      do_reset();
      test_simultaneous();
      test_back_to_back();
      test_random();
      test_carry();
      test_clr_mid();
      test_clr_idle();
      test_overflow();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
